// File: rtl/sort_frame_loader_if.sv
// ----------------------------------------------------------------------------
// sort_stream_if / sort_launch_if
//
// Bundles used by sort_frame_loader.
//
// sort_stream_if : serial valid/ready sample stream.
//   master drives in_valid, in_data, in_last; slave drives in_ready.
//   A sample moves on a rising edge where in_valid & in_ready.
//
// sort_launch_if : parallel frame hand-off to the sorter.
//   master (loader) drives sort_data[N] and sort_start;
//   slave (sorter) drives the sort_done pulse.
// ----------------------------------------------------------------------------
interface sort_stream_if #(
  parameter int WIDTH = 8
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;

  modport master (output in_valid, output in_data, output in_last, input in_ready);
  modport slave  (input in_valid, input in_data, input in_last, output in_ready);
endinterface

interface sort_launch_if #(
  parameter int N     = 6,
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] sort_data [N];
  logic             sort_start;
  logic             sort_done;

  modport master (output sort_data, output sort_start, input sort_done);
  modport slave  (input sort_data, input sort_start, output sort_done);
endinterface

// File: rtl/sort_frame_loader.sv
// ----------------------------------------------------------------------------
// sort_frame_loader
//
// Upstream feeder for a parallel sorter. Samples arriving on a serial
// valid/ready stream are collected into a frame of N slots. A full frame, or
// a short frame closed by in_last, is launched with a one-cycle sort_start
// pulse, and the frame is held stable until the sorter answers with
// sort_done. Unfilled slots of a short frame are written with PAD_VAL so that
// they sort to the top end. If the sorter stays silent for TIMEOUT cycles the
// loader gives up, flags timeout_err (sticky until the next launch) and
// returns to collecting samples.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous active-high reset
//   in_s         sort_stream_if.slave : in_valid/in_data/in_last in, in_ready out
//   sort_m       sort_launch_if.master: sort_data[N]/sort_start out, sort_done in
//   frame_len    out  real (non-pad) samples in the most recently launched frame
//   busy         out  high whenever the loader is not collecting samples
//   timeout_err  out  sticky: last launched frame was never acknowledged
// ----------------------------------------------------------------------------
module sort_frame_loader #(
  parameter int               N       = 6,
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] PAD_VAL = '1,
  parameter int               TIMEOUT = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  sort_stream_if.slave             in_s,
  sort_launch_if.master            sort_m,
  output logic [$clog2(N+1)-1:0]   frame_len,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int CNT_W = $clog2(N + 1);
  localparam int TMR_W = $clog2(TIMEOUT);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N - 1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    PAD    = 2'd1,
    LAUNCH = 2'd2,
    WAIT   = 2'd3
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [TMR_W-1:0] timer;
  logic [WIDTH-1:0] data_r [N];
  logic             start_r;
  logic             ready;
  logic             xfer;

  assign xfer = in_s.in_valid & ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    unique case (state)
      FILL: begin
        if (xfer) begin
          // A frame is closed by the Nth sample regardless of in_last.
          if (cnt == LAST_IDX) begin
            state_nxt = LAUNCH;
          end else if (in_s.in_last) begin
            state_nxt = PAD;
          end
        end
      end
      PAD:    state_nxt = LAUNCH;
      LAUNCH: state_nxt = WAIT;
      WAIT: begin
        if (sort_m.sort_done || (timer == TMR_LAST)) begin
          state_nxt = FILL;
        end
      end
      default: state_nxt = FILL;
    endcase
  end

  // Output logic
  always_comb begin
    ready             = (state == FILL) & ~rst;
    in_s.in_ready     = ready;
    busy              = (state != FILL);
    sort_m.sort_start = start_r;
    sort_m.sort_data  = data_r;
  end

  // Frame storage, counters and status
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt         <= '0;
      timer       <= '0;
      start_r     <= 1'b0;
      frame_len   <= '0;
      timeout_err <= 1'b0;
      for (int k = 0; k < N; k++) begin
        data_r[k] <= '0;
      end
    end else begin
      // Registered launch pulse: high exactly while the FSM sits in LAUNCH,
      // and the state before LAUNCH never holds it high.
      start_r <= (state_nxt == LAUNCH);

      unique case (state)
        FILL: begin
          if (xfer) begin
            for (int k = 0; k < N; k++) begin
              if (CNT_W'(k) == cnt) begin
                data_r[k] <= in_s.in_data;
              end
            end
            cnt <= cnt + CNT_W'(1);
          end
        end
        PAD: begin
          // cnt holds the number of real samples; everything above is padded.
          for (int k = 0; k < N; k++) begin
            if (CNT_W'(k) >= cnt) begin
              data_r[k] <= PAD_VAL;
            end
          end
        end
        LAUNCH: begin
          frame_len   <= cnt;
          timeout_err <= 1'b0;
          timer       <= '0;
        end
        WAIT: begin
          timer <= timer + TMR_W'(1);
          // An acknowledge arriving on the timeout cycle takes priority.
          if (sort_m.sort_done) begin
            cnt <= '0;
          end else if (timer == TMR_LAST) begin
            timeout_err <= 1'b1;
            cnt         <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sort_frame_loader.sv
// ----------------------------------------------------------------------------
// tb_sort_frame_loader
//
// Directed bench for sort_frame_loader (N=6, WIDTH=8, PAD_VAL=FF,
// TIMEOUT=32). Inputs are driven 1 time unit after each rising edge and
// outputs are sampled at the same point, away from the active edge.
// ----------------------------------------------------------------------------
module tb_sort_frame_loader;

  localparam int N     = 6;
  localparam int WIDTH = 8;

  logic             clk;
  logic             rst;
  logic [2:0]       frame_len;
  logic             busy;
  logic             timeout_err;
  logic [WIDTH-1:0] exp_d [N];

  int n_chk;
  int n_pass;

  sort_stream_if #(.WIDTH(WIDTH))         st ();
  sort_launch_if #(.N(N), .WIDTH(WIDTH))  sl ();

  sort_frame_loader #(
    .N       (N),
    .WIDTH   (WIDTH),
    .PAD_VAL (8'hFF),
    .TIMEOUT (32)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_s        (st),
    .sort_m      (sl),
    .frame_len   (frame_len),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_data(input string tag);
    for (int k = 0; k < N; k++) begin
      chk($sformatf("%s[%0d]", tag, k), 32'(sl.sort_data[k]), 32'(exp_d[k]));
    end
  endtask

  // Offer one sample for one edge; the loader must be ready for it.
  task automatic push(input logic [7:0] d, input logic l);
    chk("push_ready", 32'(st.in_ready), 32'd1);
    st.in_valid = 1'b1;
    st.in_data  = d;
    st.in_last  = l;
    tick();
    st.in_valid = 1'b0;
    st.in_last  = 1'b0;
  endtask

  task automatic ack();
    sl.sort_done = 1'b1;
    tick();
    sl.sort_done = 1'b0;
  endtask

  initial begin
    n_chk        = 0;
    n_pass       = 0;
    rst          = 1'b1;
    st.in_valid  = 1'b0;
    st.in_data   = '0;
    st.in_last   = 1'b0;
    sl.sort_done = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_ready", 32'(st.in_ready), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_start", 32'(sl.sort_start), 32'd0);
    chk("rst_len", 32'(frame_len), 32'd0);
    chk("rst_terr", 32'(timeout_err), 32'd0);
    exp_d = '{default: 8'h00};
    check_data("rst_data");
    rst = 1'b0;
    #1;
    chk("idle_ready", 32'(st.in_ready), 32'd1);

    // Full frame, in_last on the sixth sample
    push(8'd5, 1'b0);
    push(8'd3, 1'b0);
    push(8'd9, 1'b0);
    push(8'd1, 1'b0);
    push(8'd7, 1'b0);
    chk("t1_pre_start", 32'(sl.sort_start), 32'd0);
    push(8'd2, 1'b1);
    chk("t1_start", 32'(sl.sort_start), 32'd1);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_ready_launch", 32'(st.in_ready), 32'd0);
    exp_d = '{8'd5, 8'd3, 8'd9, 8'd1, 8'd7, 8'd2};
    check_data("t1_data");
    // Upstream keeps offering a sample throughout WAIT
    st.in_valid = 1'b1;
    st.in_data  = 8'h77;
    tick();
    chk("t1_start_low", 32'(sl.sort_start), 32'd0);
    chk("t1_len", 32'(frame_len), 32'd6);
    chk("t1_ready_wait", 32'(st.in_ready), 32'd0);
    tick();
    tick();
    chk("t1_ready_wait2", 32'(st.in_ready), 32'd0);
    st.in_valid = 1'b0;
    ack();
    chk("t1_done_busy", 32'(busy), 32'd0);
    chk("t1_done_ready", 32'(st.in_ready), 32'd1);
    chk("t1_len_hold", 32'(frame_len), 32'd6);
    check_data("t1_hold");

    // sort_done while collecting is ignored
    ack();
    chk("t5_fill_done_busy", 32'(busy), 32'd0);
    chk("t5_fill_done_start", 32'(sl.sort_start), 32'd0);

    // Short frame of three
    push(8'd4, 1'b0);
    push(8'd8, 1'b0);
    push(8'd1, 1'b1);
    chk("t2_pad_start", 32'(sl.sort_start), 32'd0);
    chk("t2_pad_busy", 32'(busy), 32'd1);
    chk("t2_pad_ready", 32'(st.in_ready), 32'd0);
    tick();
    chk("t2_start", 32'(sl.sort_start), 32'd1);
    exp_d = '{8'd4, 8'd8, 8'd1, 8'hFF, 8'hFF, 8'hFF};
    check_data("t2_data");
    tick();
    chk("t2_len", 32'(frame_len), 32'd3);
    chk("t2_start_low", 32'(sl.sort_start), 32'd0);
    ack();
    chk("t2_done_busy", 32'(busy), 32'd0);

    // Single-sample frame
    push(8'h2A, 1'b1);
    chk("t3_pad_start", 32'(sl.sort_start), 32'd0);
    tick();
    chk("t3_start", 32'(sl.sort_start), 32'd1);
    exp_d = '{8'h2A, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    check_data("t3_data");
    tick();
    chk("t3_len", 32'(frame_len), 32'd1);
    ack();

    // Full frame never acknowledged
    push(8'h10, 1'b0);
    push(8'h11, 1'b0);
    push(8'h12, 1'b0);
    push(8'h13, 1'b0);
    push(8'h14, 1'b0);
    push(8'h15, 1'b0);
    chk("t4_start", 32'(sl.sort_start), 32'd1);
    tick();
    repeat (31) tick();
    chk("t4_wait31_busy", 32'(busy), 32'd1);
    chk("t4_wait31_terr", 32'(timeout_err), 32'd0);
    tick();
    chk("t4_to_busy", 32'(busy), 32'd0);
    chk("t4_to_terr", 32'(timeout_err), 32'd1);
    chk("t4_to_ready", 32'(st.in_ready), 32'd1);
    push(8'h33, 1'b1);
    tick();
    chk("t4_launch_terr", 32'(timeout_err), 32'd1);
    tick();
    chk("t4_relaunch_terr", 32'(timeout_err), 32'd0);
    chk("t4_len", 32'(frame_len), 32'd1);

    // Acknowledge on the timeout cycle: done wins
    repeat (31) tick();
    chk("t5_edge_busy", 32'(busy), 32'd1);
    ack();
    chk("t5_edge_busy_after", 32'(busy), 32'd0);
    chk("t5_edge_terr", 32'(timeout_err), 32'd0);

    // Reset in the middle of WAIT
    push(8'hA1, 1'b0);
    push(8'hA2, 1'b0);
    push(8'hA3, 1'b0);
    push(8'hA4, 1'b0);
    push(8'hA5, 1'b0);
    push(8'hA6, 1'b0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    chk("t6_rst_ready", 32'(st.in_ready), 32'd0);
    chk("t6_rst_busy", 32'(busy), 32'd0);
    chk("t6_rst_start", 32'(sl.sort_start), 32'd0);
    chk("t6_rst_len", 32'(frame_len), 32'd0);
    chk("t6_rst_terr", 32'(timeout_err), 32'd0);
    exp_d = '{default: 8'h00};
    check_data("t6_rst_data");
    rst = 1'b0;
    #1;
    push(8'd6, 1'b0);
    push(8'd5, 1'b0);
    push(8'd4, 1'b0);
    push(8'd3, 1'b0);
    push(8'd2, 1'b0);
    push(8'd1, 1'b1);
    chk("t6_start", 32'(sl.sort_start), 32'd1);
    exp_d = '{8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    check_data("t6_data");
    tick();
    chk("t6_len", 32'(frame_len), 32'd6);
    ack();
    chk("t6_done_busy", 32'(busy), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
